// File: rtl/label_select.sv
// label_select -- sequential arg-min stage of the K-Means datapath.
//
// Accepts one set of eight unsigned squared distances, scans them one compare
// per cycle, and returns the index of the smallest distance (label) together
// with that distance (min_dist). Ties resolve to the lowest index.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its data stable until then.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_ready    input handshake for dist0..dist7
//   dist0..dist7          squared distances to centers 0..7
//   out_valid, out_ready  output handshake for label/min_dist
//   label, min_dist       winning index and its distance
//   hist_clr              synchronous clear of the label histogram
//   hist_sel, hist_count  combinational histogram read port
//
// Optional feature: define LABEL_HIST_EN to build the per-label assignment
// histogram. Without it hist_count is tied to zero.
module label_select #(
    parameter int DIST_W        = 33,
    parameter int NUM_LABEL     = 8,
    parameter int LOG_NUM_LABEL = 3,
    parameter int CNT_W         = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIST_W-1:0]        dist0,
    input  logic [DIST_W-1:0]        dist1,
    input  logic [DIST_W-1:0]        dist2,
    input  logic [DIST_W-1:0]        dist3,
    input  logic [DIST_W-1:0]        dist4,
    input  logic [DIST_W-1:0]        dist5,
    input  logic [DIST_W-1:0]        dist6,
    input  logic [DIST_W-1:0]        dist7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LOG_NUM_LABEL-1:0] label,
    output logic [DIST_W-1:0]        min_dist,
    input  logic                     hist_clr,
    input  logic [LOG_NUM_LABEL-1:0] hist_sel,
    output logic [CNT_W-1:0]         hist_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // state is the FSM register; checkers can bind to it directly.
    state_t state, state_next;

    logic [DIST_W-1:0]        dist_buf [NUM_LABEL];
    logic [DIST_W-1:0]        best_dist;
    logic [LOG_NUM_LABEL-1:0] best_idx;
    logic [LOG_NUM_LABEL-1:0] scan_idx;
    logic                     accept;
    logic                     handshake;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                // Gated with rst so in_ready is low for the whole reset pulse.
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_idx == LOG_NUM_LABEL'(NUM_LABEL - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: entry 0 seeds the running minimum, entries 1..7 are scanned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_dist <= '0;
            best_idx  <= '0;
            scan_idx  <= '0;
            for (int i = 0; i < NUM_LABEL; i++) begin
                dist_buf[i] <= '0;
            end
        end else if (accept) begin
            dist_buf[0] <= dist0;
            dist_buf[1] <= dist1;
            dist_buf[2] <= dist2;
            dist_buf[3] <= dist3;
            dist_buf[4] <= dist4;
            dist_buf[5] <= dist5;
            dist_buf[6] <= dist6;
            dist_buf[7] <= dist7;
            best_dist   <= dist0;
            best_idx    <= '0;
            scan_idx    <= LOG_NUM_LABEL'(1);
        end else if (state == SCAN) begin
            // Strict less-than keeps the earlier index on a tie.
            if (dist_buf[scan_idx] < best_dist) begin
                best_dist <= dist_buf[scan_idx];
                best_idx  <= scan_idx;
            end
            scan_idx <= scan_idx + LOG_NUM_LABEL'(1);
        end
    end

    assign label    = best_idx;
    assign min_dist = best_dist;

`ifdef LABEL_HIST_EN
    logic [CNT_W-1:0] count [NUM_LABEL];

    // A clear on the same edge as a handshake leaves the winning label at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LABEL; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LABEL; i++) begin
                if (handshake && (best_idx == LOG_NUM_LABEL'(i))) begin
                    if (hist_clr) begin
                        count[i] <= CNT_W'(1);
                    end else if (count[i] != '1) begin
                        count[i] <= count[i] + CNT_W'(1);
                    end
                end else if (hist_clr) begin
                    count[i] <= '0;
                end
            end
        end
    end

    assign hist_count = count[hist_sel];
`else
    logic unused_hist;
    assign unused_hist = ^{hist_clr, hist_sel, handshake};
    assign hist_count  = '0;
`endif

endmodule

// File: doc/label_select.md
# label_select

Sequential arg-min stage of the K-Means datapath: consumes the eight squared distances produced by the distance stage for one point and returns the index of the nearest center (the point's label) plus the winning distance. It sits between the distance stage and the center-update logic. A valid/ready handshake runs on both sides, and one compare is resolved per cycle to keep logic depth at a single 33-bit comparator. An optional per-label assignment histogram is provided for the center-update stage.

## Interface
- DIST_W, 33, width of each squared distance (2*16+1)
- NUM_LABEL, 8, number of centers; fixed at 8 (eight distance ports)
- LOG_NUM_LABEL, 3, label width
- CNT_W, 11, histogram counter width (holds 0..1024 points)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  dist0..dist7 valid
- in_ready  out  1  block can accept a distance set
- dist0..dist7  in  DIST_W each  unsigned squared distance to center 0..7
- out_valid  out  1  label/min_dist valid
- out_ready  in  1  downstream accepts result
- label  out  LOG_NUM_LABEL  index of minimum distance
- min_dist  out  DIST_W  minimum distance value
- hist_clr  in  1  synchronous clear of all histogram counters
- hist_sel  in  LOG_NUM_LABEL  histogram read select
- hist_count  out  CNT_W  count for label hist_sel (combinational read)

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. If in_valid, all eight distances are latched into a local buffer. best_dist<=dist0, best_idx<=0, scan index<=1, and the FSM moves to SCAN.
- SCAN: each cycle compares buf[idx] against best_dist, unsigned strict less-than. On less-than, best_dist<=buf[idx] and best_idx<=idx. idx increments. After idx==7 is processed, the FSM moves to DONE.
- Ties: strict compare, so the lowest index wins.
- DONE: out_valid=1, with label=best_idx and min_dist=best_dist held stable. If out_ready, the FSM returns to IDLE.
- in_valid outside IDLE is ignored. Upstream must hold data until in_ready.
- Distances are treated as unsigned DIST_W values with no arithmetic on them, so there is no overflow case.
- Reset (any state): FSM goes to IDLE. Any in-flight set is discarded and no output is produced. Histogram counters are cleared.

## Timing
- While rst is high: in_ready=0, out_valid=0, label=0, min_dist=0, all counters=0, hist_count=0.
- in_ready=1 in the first cycle after rst deasserts.
- Accept edge T (in_valid&&in_ready): SCAN occupies edges T+1..T+7, and out_valid is high after edge T+7 (latency 7 cycles).
- Output handshake edge U: out_valid drops and in_ready=1 after U. The earliest next accept is edge U+1.
- Back-to-back throughput is one set per 9 cycles when out_ready is held high.
- out_ready low in DONE: the outputs hold indefinitely with no loss.

## Configuration
- LABEL_HIST_EN defined: eight CNT_W counters are built. On each output handshake, count[label] increments, saturating at 2^CNT_W-1. hist_clr zeroes all counters at the next edge. If hist_clr and an output handshake fall on the same edge, clear wins for the other labels and count[label] becomes 1. hist_count = count[hist_sel].
- LABEL_HIST_EN undefined: no counters are built. hist_count is tied to 0, and hist_clr and hist_sel are ignored. The label path is unchanged.

## Test plan
- Reset then single set {dist0..7}={90,40,75,40,200,41,300,99}, out_ready=1 -> out_valid 7 cycles after accept; label=1 (tie with index 3 resolved low), min_dist=40.
- All distances equal 0x1_FFFF_FFFF -> label=0, min_dist=0x1_FFFF_FFFF. Minimum at index 7 only (dist7=0, others 5) -> label=7, min_dist=0.
- Backpressure: out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> one handshake, then in_ready=1 on the next cycle.
- Assert rst asynchronously mid-SCAN (3 cycles after accept) -> out_valid=0 and in_ready=0 immediately. After release, no stale result appears and the next set resolves correctly.
- LABEL_HIST_EN: 5 sets with labels 2,2,5,2,0 -> hist_count for sel 2/5/0/7 = 3/1/1/0. hist_clr on the same edge as a label-5 handshake -> count[5]=1 and all other counts 0.
- LABEL_HIST_EN undefined: the same 5 sets -> hist_count=0 for every hist_sel, and labels are identical to the enabled build.
